// File: rtl/alu_defs_pkg.sv
// Shared ALU encodings: aluSel operation codes, aluOp instruction classes and datapath widths.
package alu_defs;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned SEL_W  = 4;
  localparam int unsigned OP_W   = 2;
  localparam int unsigned F3_W   = 3;

  localparam logic [SEL_W-1:0] ALU_AND = 4'b0000;
  localparam logic [SEL_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [SEL_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [SEL_W-1:0] ALU_SUB = 4'b0110;
  localparam logic [SEL_W-1:0] ALU_BAD = 4'b1111;

  localparam logic [OP_W-1:0] ALUOP_MEM = 2'b00;
  localparam logic [OP_W-1:0] ALUOP_BR  = 2'b01;
  localparam logic [OP_W-1:0] ALUOP_R   = 2'b10;
  localparam logic [OP_W-1:0] ALUOP_I   = 2'b11;

  localparam logic [F3_W-1:0] F3_ADD = 3'b000;
  localparam logic [F3_W-1:0] F3_OR  = 3'b110;
  localparam logic [F3_W-1:0] F3_AND = 3'b111;

endpackage

// File: rtl/alu_control.sv
// Combinational ALU operation decode from aluOp, funct3 and funct7 bit 30.
module alu_control
  import alu_defs::*;
(
  input  logic [OP_W-1:0]  aluOp,
  input  logic [F3_W-1:0]  funct3,
  input  logic             funct7_30,
  output logic [SEL_W-1:0] aluSel
);

  always_comb begin
    aluSel = ALU_BAD;
    unique case (aluOp)
      ALUOP_MEM: aluSel = ALU_ADD;
      ALUOP_BR:  aluSel = ALU_SUB;
      ALUOP_R: begin
        case (funct3)
          F3_ADD:  aluSel = funct7_30 ? ALU_SUB : ALU_ADD;
          F3_AND:  aluSel = ALU_AND;
          F3_OR:   aluSel = ALU_OR;
          default: aluSel = ALU_BAD;
        endcase
      end
      ALUOP_I: begin
        // funct7_30 is part of the immediate here, so it must not select SUB
        case (funct3)
          F3_ADD:  aluSel = ALU_ADD;
          F3_AND:  aluSel = ALU_AND;
          F3_OR:   aluSel = ALU_OR;
          default: aluSel = ALU_BAD;
        endcase
      end
      default: aluSel = ALU_BAD;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU control decode and EX-side operand selection.
// Define ID_EX_FORWARDING_EN to enable EX/MEM and MEM/WB operand forwarding.
module id_ex_stage
  import alu_defs::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   rs1_data,
  input  logic [XLEN-1:0]   rs2_data,
  input  logic [XLEN-1:0]   imm,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  input  logic [REG_AW-1:0] rd,
  input  logic [OP_W-1:0]   aluOp,
  input  logic [F3_W-1:0]   funct3,
  input  logic              funct7_30,
  input  logic              aluSrc,
  input  logic              regWrite,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic              memtoReg,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic              exmem_regWrite,
  input  logic [XLEN-1:0]   exmem_result,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic              memwb_regWrite,
  input  logic [XLEN-1:0]   memwb_result,
  output logic [XLEN-1:0]   in1,
  output logic [XLEN-1:0]   in2,
  output logic [SEL_W-1:0]  aluSel,
  output logic [XLEN-1:0]   store_data,
  output logic [REG_AW-1:0] rd_out,
  output logic              ex_valid,
  output logic              regWrite_out,
  output logic              memRead_out,
  output logic              memWrite_out,
  output logic              memtoReg_out
);

  logic [SEL_W-1:0]  sel_d;
  logic [XLEN-1:0]   rs1_data_q;
  logic [XLEN-1:0]   rs2_data_q;
  logic [XLEN-1:0]   imm_q;
  logic [REG_AW-1:0] rs1_q;
  logic [REG_AW-1:0] rs2_q;
  logic              aluSrc_q;
  logic [XLEN-1:0]   op_a;
  logic [XLEN-1:0]   op_b;

  alu_control u_alu_control (
    .aluOp     (aluOp),
    .funct3    (funct3),
    .funct7_30 (funct7_30),
    .aluSel    (sel_d)
  );

  // Priority: reset, then flush, then stall; an invalid ID slot loads a bubble.
  // A bubble clears only the control fields; operand fields are don't-care.
  always_ff @(posedge clk) begin
    if (rst) begin
      rs1_data_q   <= '0;
      rs2_data_q   <= '0;
      imm_q        <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      aluSrc_q     <= 1'b0;
      aluSel       <= '0;
      rd_out       <= '0;
      ex_valid     <= 1'b0;
      regWrite_out <= 1'b0;
      memRead_out  <= 1'b0;
      memWrite_out <= 1'b0;
      memtoReg_out <= 1'b0;
    end else if (flush || (!stall && !id_valid)) begin
      rd_out       <= '0;
      ex_valid     <= 1'b0;
      regWrite_out <= 1'b0;
      memRead_out  <= 1'b0;
      memWrite_out <= 1'b0;
      memtoReg_out <= 1'b0;
    end else if (!stall) begin
      rs1_data_q   <= rs1_data;
      rs2_data_q   <= rs2_data;
      imm_q        <= imm;
      rs1_q        <= rs1;
      rs2_q        <= rs2;
      aluSrc_q     <= aluSrc;
      aluSel       <= sel_d;
      rd_out       <= rd;
      ex_valid     <= 1'b1;
      regWrite_out <= regWrite;
      memRead_out  <= memRead;
      memWrite_out <= memWrite;
      memtoReg_out <= memtoReg;
    end
  end

`ifdef ID_EX_FORWARDING_EN
  // Youngest producer wins; x0 is hardwired zero and never forwarded.
  always_comb begin
    op_a = rs1_data_q;
    if (rs1_q != '0 && exmem_regWrite && exmem_rd == rs1_q) begin
      op_a = exmem_result;
    end else if (rs1_q != '0 && memwb_regWrite && memwb_rd == rs1_q) begin
      op_a = memwb_result;
    end
  end

  always_comb begin
    op_b = rs2_data_q;
    if (rs2_q != '0 && exmem_regWrite && exmem_rd == rs2_q) begin
      op_b = exmem_result;
    end else if (rs2_q != '0 && memwb_regWrite && memwb_rd == rs2_q) begin
      op_b = memwb_result;
    end
  end
`else
  logic unused_fwd;

  assign op_a = rs1_data_q;
  assign op_b = rs2_data_q;
  assign unused_fwd = ^{exmem_rd, exmem_regWrite, exmem_result,
                        memwb_rd, memwb_regWrite, memwb_result, rs1_q, rs2_q};
`endif

  assign in1        = op_a;
  assign in2        = aluSrc_q ? imm_q : op_b;
  assign store_data = op_b;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed cases plus randomized traffic against a
// behavioural model of the instruction held in EX. Honours ID_EX_FORWARDING_EN.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush, id_valid;
  logic [31:0] rs1_data, rs2_data, imm;
  logic [4:0]  rs1, rs2, rd;
  logic [1:0]  aluOp;
  logic [2:0]  funct3;
  logic        funct7_30, aluSrc, regWrite, memRead, memWrite, memtoReg;
  logic [4:0]  exmem_rd, memwb_rd;
  logic        exmem_regWrite, memwb_regWrite;
  logic [31:0] exmem_result, memwb_result;
  logic [31:0] in1, in2, store_data;
  logic [3:0]  aluSel;
  logic [4:0]  rd_out;
  logic        ex_valid, regWrite_out, memRead_out, memWrite_out, memtoReg_out;

  int checks = 0;
  int errors = 0;

  // Model of the instruction currently in EX.
  logic        m_valid, m_rw, m_mr, m_mw, m_m2r, m_src, m_known;
  logic [4:0]  m_rd, m_rs1, m_rs2;
  logic [31:0] m_d1, m_d2, m_imm;
  logic [3:0]  m_sel;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
    .rs1(rs1), .rs2(rs2), .rd(rd),
    .aluOp(aluOp), .funct3(funct3), .funct7_30(funct7_30),
    .aluSrc(aluSrc), .regWrite(regWrite), .memRead(memRead), .memWrite(memWrite),
    .memtoReg(memtoReg),
    .exmem_rd(exmem_rd), .exmem_regWrite(exmem_regWrite), .exmem_result(exmem_result),
    .memwb_rd(memwb_rd), .memwb_regWrite(memwb_regWrite), .memwb_result(memwb_result),
    .in1(in1), .in2(in2), .aluSel(aluSel), .store_data(store_data), .rd_out(rd_out),
    .ex_valid(ex_valid), .regWrite_out(regWrite_out), .memRead_out(memRead_out),
    .memWrite_out(memWrite_out), .memtoReg_out(memtoReg_out)
  );

  function automatic logic [3:0] exp_sel(input logic [1:0] op, input logic [2:0] f3,
                                         input logic f7);
    if (op == 2'd0) return 4'b0010;
    if (op == 2'd1) return 4'b0110;
    if (f3 == 3'b000) return (op == 2'd2 && f7) ? 4'b0110 : 4'b0010;
    if (f3 == 3'b111) return 4'b0000;
    if (f3 == 3'b110) return 4'b0001;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] d);
`ifdef ID_EX_FORWARDING_EN
    if (rs != 5'd0 && exmem_regWrite && exmem_rd == rs) return exmem_result;
    if (rs != 5'd0 && memwb_regWrite && memwb_rd == rs) return memwb_result;
`endif
    return d;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic defaults();
    rst = 1'b0; stall = 1'b0; flush = 1'b0; id_valid = 1'b1;
    rs1_data = '0; rs2_data = '0; imm = '0; rs1 = '0; rs2 = '0; rd = '0;
    aluOp = '0; funct3 = '0; funct7_30 = 1'b0; aluSrc = 1'b0;
    regWrite = 1'b0; memRead = 1'b0; memWrite = 1'b0; memtoReg = 1'b0;
    exmem_rd = '0; exmem_regWrite = 1'b0; exmem_result = '0;
    memwb_rd = '0; memwb_regWrite = 1'b0; memwb_result = '0;
  endtask

  // Next EX contents from the current inputs.
  task automatic model_clock();
    if (rst) begin
      {m_valid, m_rw, m_mr, m_mw, m_m2r, m_src} = '0;
      m_rd = '0; m_rs1 = '0; m_rs2 = '0; m_d1 = '0; m_d2 = '0; m_imm = '0; m_sel = '0;
      m_known = 1'b1;
    end else if (flush || (!stall && !id_valid)) begin
      {m_valid, m_rw, m_mr, m_mw, m_m2r} = '0;
      m_rd = '0;
      m_known = 1'b0;
    end else if (!stall) begin
      m_valid = 1'b1; m_rw = regWrite; m_mr = memRead; m_mw = memWrite; m_m2r = memtoReg;
      m_src = aluSrc; m_rd = rd; m_rs1 = rs1; m_rs2 = rs2;
      m_d1 = rs1_data; m_d2 = rs2_data; m_imm = imm;
      m_sel = exp_sel(aluOp, funct3, funct7_30);
      m_known = 1'b1;
    end
  endtask

  task automatic check_all();
    chk("ex_valid", 32'(ex_valid), 32'(m_valid));
    chk("regWrite_out", 32'(regWrite_out), 32'(m_rw));
    chk("memRead_out", 32'(memRead_out), 32'(m_mr));
    chk("memWrite_out", 32'(memWrite_out), 32'(m_mw));
    chk("memtoReg_out", 32'(memtoReg_out), 32'(m_m2r));
    chk("rd_out", 32'(rd_out), 32'(m_rd));
    if (m_known) begin
      chk("aluSel", 32'(aluSel), 32'(m_sel));
      chk("in1", in1, fwd(m_rs1, m_d1));
      chk("in2", in2, m_src ? m_imm : fwd(m_rs2, m_d2));
      chk("store_data", store_data, fwd(m_rs2, m_d2));
    end
  endtask

  task automatic step();
    model_clock();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic randomize_inputs();
    rs1_data = $urandom; rs2_data = $urandom; imm = $urandom;
    rs1 = 5'($urandom_range(0, 7)); rs2 = 5'($urandom_range(0, 7)); rd = 5'($urandom);
    aluOp = 2'($urandom);
    funct3 = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'($urandom_range(6, 7));
    funct7_30 = 1'($urandom); aluSrc = 1'($urandom);
    regWrite = 1'($urandom); memRead = 1'($urandom);
    memWrite = 1'($urandom); memtoReg = 1'($urandom);
    exmem_rd = 5'($urandom_range(0, 7)); exmem_regWrite = 1'($urandom);
    exmem_result = $urandom;
    memwb_rd = 5'($urandom_range(0, 7)); memwb_regWrite = 1'($urandom);
    memwb_result = $urandom;
  endtask

  initial begin
    defaults();
    rst = 1'b1; stall = 1'b1; flush = 1'b1;
    step();
    chk("reset_in1", in1, 32'd0);
    chk("reset_aluSel", 32'(aluSel), 32'd0);
    rst = 1'b0; stall = 1'b0; flush = 1'b0;

    // R-type SUB
    aluOp = 2'b10; funct3 = 3'b000; funct7_30 = 1'b1; rs1 = 5'd1; rs2 = 5'd2; rd = 5'd3;
    rs1_data = 32'd10; rs2_data = 32'd3; regWrite = 1'b1;
    step();
    chk("sub_aluSel", 32'(aluSel), 32'h6);
    chk("sub_in1", in1, 32'd10);
    chk("sub_in2", in2, 32'd3);
    chk("sub_valid", 32'(ex_valid), 32'd1);

    // ADDI: immediate feeds in2, store_data still sees rs2
    aluOp = 2'b11; funct3 = 3'b000; funct7_30 = 1'b1; aluSrc = 1'b1; imm = 32'd5;
    rs2_data = 32'd99;
    step();
    chk("addi_in2", in2, 32'd5);
    chk("addi_store", store_data, 32'd99);
    chk("addi_aluSel", 32'(aluSel), 32'h2);

    // Forwarding from x4: EX/MEM beats MEM/WB
    aluOp = 2'b10; funct7_30 = 1'b0; aluSrc = 1'b0; rs1 = 5'd4; rs1_data = 32'd50;
    step();
    exmem_rd = 5'd4; exmem_regWrite = 1'b1; exmem_result = 32'd7;
    memwb_rd = 5'd4; memwb_regWrite = 1'b1; memwb_result = 32'd8;
    #1;
    check_all();
`ifdef ID_EX_FORWARDING_EN
    chk("fwd_exmem_in1", in1, 32'd7);
`else
    chk("nofwd_in1", in1, 32'd50);
`endif
    exmem_regWrite = 1'b0;
    #1;
    check_all();
    // x0 is never forwarded
    rs1 = 5'd0; rs1_data = 32'd123; exmem_rd = 5'd0; exmem_regWrite = 1'b1;
    memwb_rd = 5'd0;
    step();
    chk("x0_in1", in1, 32'd123);

    // Stall for 3 cycles with changing inputs
    defaults();
    aluOp = 2'b10; funct3 = 3'b111; rs1_data = 32'hAAAA; rs2_data = 32'h5555; rd = 5'd9;
    regWrite = 1'b1; memWrite = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      randomize_inputs();
      stall = 1'b1; flush = 1'b0; id_valid = 1'b1;
      exmem_regWrite = 1'b0; memwb_regWrite = 1'b0;
      step();
      chk("stall_in1", in1, 32'hAAAA);
      chk("stall_rd", 32'(rd_out), 32'd9);
    end
    flush = 1'b1;
    step();
    chk("flush_valid", 32'(ex_valid), 32'd0);
    chk("flush_rw", 32'(regWrite_out), 32'd0);

    // Reset during a stall discards the held instruction
    defaults();
    rs1_data = 32'd77; rs2_data = 32'd66; rd = 5'd5; regWrite = 1'b1; aluOp = 2'b01;
    step();
    stall = 1'b1;
    step();
    rst = 1'b1;
    step();
    chk("rst_stall_in1", in1, 32'd0);
    chk("rst_stall_store", store_data, 32'd0);
    chk("rst_stall_aluSel", 32'(aluSel), 32'd0);
    defaults();

    // Unsupported R-type funct3
    aluOp = 2'b10; funct3 = 3'b010; regWrite = 1'b1;
    step();
    chk("bad_aluSel", 32'(aluSel), 32'hF);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      randomize_inputs();
      rst = ($urandom_range(0, 99) < 3);
      stall = ($urandom_range(0, 99) < 20);
      flush = ($urandom_range(0, 99) < 10);
      id_valid = ($urandom_range(0, 99) < 85);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL: stall  input  1  hold all pipeline registers; flush  input  1  load a bubble.
REQ-004 SHALL: id_valid  input  1; rs1_data, rs2_data, imm  input  32 each; rs1, rs2, rd  input  5 each.
REQ-005 SHALL: aluOp  input  2; funct3  input  3; funct7_30  input  1; aluSrc, regWrite, memRead, memWrite, memtoReg  input  1 each.
REQ-006 SHALL: exmem_rd  input  5; exmem_regWrite  input  1; exmem_result  input  32; memwb_rd, memwb_regWrite, memwb_result  same widths.
REQ-007 SHALL: in1, in2  output  32  ALU operands; aluSel  output  4  ALU operation select.
REQ-008 SHALL: store_data  output  32; rd_out  output  5; ex_valid, regWrite_out, memRead_out, memWrite_out, memtoReg_out  output  1 each.

Function
REQ-009 SHALL: register all ID inputs plus decoded aluSel on each edge when rst=0, stall=0 and flush=0; latency 1 cycle.
REQ-010 SHALL: on stall=1 (flush=0), hold every register unchanged.
REQ-011 SHALL: on flush=1, clear ex_valid, regWrite, memRead, memWrite, memtoReg and rd to 0, regardless of stall (flush wins).
REQ-012 SHALL: with id_valid=0, capture as bubble (same values as flush).
REQ-013 SHALL: decode aluSel: aluOp 00 -> 0010; 01 -> 0110; 10 (R): funct3 000/funct7_30 0 -> 0010, 000/1 -> 0110, 111 -> 0000, 110 -> 0001.
REQ-014 SHALL: aluOp 11 (I-type): funct3 000 -> 0010 (funct7_30 ignored), 111 -> 0000, 110 -> 0001.
REQ-015 SHALL: any other combination -> aluSel 1111 (unsupported; ALU yields 0).
REQ-016 SHALL: operand A = forwarded rs1 value; in1 = A.
REQ-017 SHALL: operand B = forwarded rs2 value; in2 = imm_q when aluSrc_q=1, else B; store_data = B always.
REQ-018 SHALL: forwarding combinational in EX from registered rs1/rs2 and current-cycle exmem/memwb inputs.
REQ-019 SHALL: forward priority: EX/MEM (exmem_regWrite=1, exmem_rd=rs, rs!=0) over MEM/WB (same rule), else registered data.
REQ-020 SHALL: register x0 never forwarded; source value used unmodified.

Reset
REQ-021 SHALL: rst=1 clears every register to 0 on next edge, overriding stall and flush.
REQ-022 SHALL: after reset: in1=0, in2=0, aluSel=0000, store_data=0, rd_out=0, all valid/control outputs 0.
REQ-023 SHALL: reset asserted mid-stall discards held instruction; no state survives.

Configuration
REQ-024 SHALL: macro ID_EX_FORWARDING_EN defined -> forwarding per REQ-018..020.
REQ-025 SHALL: macro undefined -> no forwarding logic; A=rs1_data_q, B=rs2_data_q; exmem_*/memwb_* ports present but ignored.

Structure
REQ-026 SHALL: shared package/include alu_defs holds aluSel encodings (AND 0000, OR 0001, ADD 0010, SUB 0110, BAD 1111) and aluOp encodings.
REQ-027 SHALL: one combinational sub-module alu_control (aluOp, funct3, funct7_30 -> aluSel); forwarding mux stays inline.

Verification
REQ-028 SHALL: R-type sub, rs1_data=10, rs2_data=3, funct7_30=1 -> next cycle aluSel=0110, in1=10, in2=3, ex_valid=1.
REQ-029 SHALL: addi imm=5, aluSrc=1, rs2_data=99 -> in2=5, store_data=99, aluSel=0010.
REQ-030 SHALL: rs1=x4 registered, exmem_rd=4/regWrite=1/result=7 and memwb_rd=4/regWrite=1/result=8 -> in1=7; rs1=x0 with exmem_rd=0 -> in1=registered data.
REQ-031 SHALL: stall=1 for 3 cycles with changing inputs -> outputs frozen; stall=1 and flush=1 together -> bubble, ex_valid=0, regWrite_out=0.
REQ-032 SHALL: rst=1 during stall -> next cycle all outputs 0, aluSel=0000; funct3=010 with aluOp=10 -> aluSel=1111.
